// File: rtl/hit_tracker_if.sv
// hit_tracker_if: bundles the per-player hit/tick inputs from the collision
// detector with the colour, lives and game-over outputs of the hit tracker.
interface hit_tracker_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int TIMER_W     = 10,
  parameter int LIVES       = 3,
  parameter int LIFE_W      = $clog2(LIVES + 1)
);
  logic [NUM_PLAYERS-1:0]        hit;
  logic [TIMER_W-1:0]            timer;
  logic [NUM_PLAYERS-1:0]        red;
  logic [NUM_PLAYERS-1:0]        hit_ack;
  logic [NUM_PLAYERS*LIFE_W-1:0] lives;
  logic [NUM_PLAYERS-1:0]        dead;
  logic                          game_over;

  // Collision detector / game logic side
  modport master (
    output hit, timer,
    input  red, hit_ack, lives, dead, game_over
  );

  // Hit tracker side
  modport slave (
    input  hit, timer,
    output red, hit_ack, lives, dead, game_over
  );
endinterface

// File: rtl/hit_tracker.sv
// hit_tracker: per-player hit flash / invulnerability window, lives counter
// and dead flag for NUM_PLAYERS independent channels, plus a registered
// game-over flag raised once at most one player is still alive.
// Optional macro HIT_TRACKER_BLINK_EN: the hit colour blinks with timer[1]
// during the window instead of being held steady.
module hit_tracker #(
  parameter int NUM_PLAYERS = 2,
  parameter int TIMER_W     = 10,
  parameter int RED_TICKS   = 8,
  parameter int LIVES       = 3,
  parameter int RETRIGGER   = 1,
  localparam int LIFE_W     = $clog2(LIVES + 1)
) (
  input  logic           Clk,
  input  logic           Reset,
  hit_tracker_if.slave   bus_io
);

  localparam int CNT_W = $clog2(NUM_PLAYERS + 1);
  localparam logic [TIMER_W-1:0] RED_LEN    = TIMER_W'(RED_TICKS);
  localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(LIVES);

  typedef enum logic [1:0] {IDLE, RED, DEAD} state_e;

  state_e                 state_q  [NUM_PLAYERS];
  logic [TIMER_W-1:0]     start_q  [NUM_PLAYERS];
  logic [LIFE_W-1:0]      lives_q  [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] red_q;
  logic [NUM_PLAYERS-1:0] hitAck_q;
  logic [NUM_PLAYERS-1:0] dead_q;
  logic                   gameOver_q;

  logic [TIMER_W-1:0]     elapsed_d  [NUM_PLAYERS];
  logic [LIFE_W-1:0]      livesDec_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] expire_d;
  logic [NUM_PLAYERS-1:0] accept_d;
  logic [CNT_W-1:0]       aliveCount_d;
  logic                   blinkPhase_d;

  // Colour phase while inside the window: steady, or blinking on timer[1]
`ifdef HIT_TRACKER_BLINK_EN
  assign blinkPhase_d = bus_io.timer[1];
`else
  assign blinkPhase_d = 1'b1;
`endif

  // Window expiry (modular elapsed time) and hit acceptance per channel
  always_comb begin
    elapsed_d  = '{default: '0};
    livesDec_d = '{default: '0};
    expire_d   = '0;
    accept_d   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      elapsed_d[i]  = bus_io.timer - start_q[i];
      expire_d[i]   = (state_q[i] == RED) && (elapsed_d[i] >= RED_LEN);
      livesDec_d[i] = (lives_q[i] != '0) ? (lives_q[i] - LIFE_W'(1)) : '0;
      accept_d[i]   = bus_io.hit[i] &&
                      ((state_q[i] == IDLE) ||
                       ((state_q[i] == RED) && ((RETRIGGER != 0) || expire_d[i])));
    end
  end

  // Number of players still alive, from the registered dead flags
  always_comb begin
    aliveCount_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      aliveCount_d = aliveCount_d + CNT_W'(!dead_q[i]);
    end
  end

  // Per-channel IDLE/RED/DEAD state machines with registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        state_q[i] <= IDLE;
        start_q[i] <= '0;
        lives_q[i] <= LIVES_INIT;
      end
      red_q      <= '0;
      hitAck_q   <= '0;
      dead_q     <= '0;
      gameOver_q <= 1'b0;
    end else begin
      gameOver_q <= (NUM_PLAYERS >= 2) && (aliveCount_d <= CNT_W'(1));
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        hitAck_q[i] <= accept_d[i];
        unique case (state_q[i])
          IDLE, RED: begin
            if (accept_d[i]) begin
              lives_q[i] <= livesDec_d[i];
              if (livesDec_d[i] == '0) begin
                state_q[i] <= DEAD;
                red_q[i]   <= 1'b0;
                dead_q[i]  <= 1'b1;
              end else begin
                state_q[i] <= RED;
                start_q[i] <= bus_io.timer;
                red_q[i]   <= blinkPhase_d;
              end
            end else if (expire_d[i]) begin
              state_q[i] <= IDLE;
              red_q[i]   <= 1'b0;
            end else if (state_q[i] == RED) begin
              red_q[i] <= blinkPhase_d;
            end else begin
              red_q[i] <= 1'b0;
            end
          end
          DEAD: begin
            red_q[i]   <= 1'b0;
            dead_q[i]  <= 1'b1;
            lives_q[i] <= '0;
          end
          default: begin
            state_q[i] <= IDLE;
            red_q[i]   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus_io.red       = red_q;
  assign bus_io.hit_ack   = hitAck_q;
  assign bus_io.dead      = dead_q;
  assign bus_io.game_over = gameOver_q;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_lives
    assign bus_io.lives[g*LIFE_W +: LIFE_W] = lives_q[g];
  end

endmodule

// File: tb/tb_hit_tracker.sv
// tb_hit_tracker: drives two hit_tracker instances (retriggering and
// invulnerable variants) with the same hits and timer, and compares every
// output each cycle against a behavioural model of lives and hit windows.
module tb_hit_tracker;

  localparam int NP    = 2;
  localparam int TW    = 10;
  localparam int TMOD  = 1 << TW;
  localparam int RTK   = 8;
  localparam int LV    = 3;
  localparam int LW    = $clog2(LV + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checkCount = 0;
  int failCount  = 0;

  // model state: first index 0 = retrigger instance, 1 = invulnerable one
  int mLives [2][NP];
  int mStart [2][NP];
  bit mIn    [2][NP];
  bit mDead  [2][NP];
  bit mAck   [2][NP];
  bit mRed   [2][NP];
  bit mGo    [2];

  hit_tracker_if #(.NUM_PLAYERS(NP), .TIMER_W(TW), .LIVES(LV)) busA ();
  hit_tracker_if #(.NUM_PLAYERS(NP), .TIMER_W(TW), .LIVES(LV)) busB ();

  hit_tracker #(.NUM_PLAYERS(NP), .TIMER_W(TW), .RED_TICKS(RTK), .LIVES(LV), .RETRIGGER(1))
    dutA (.Clk(clk), .Reset(rst), .bus_io(busA));
  hit_tracker #(.NUM_PLAYERS(NP), .TIMER_W(TW), .RED_TICKS(RTK), .LIVES(LV), .RETRIGGER(0))
    dutB (.Clk(clk), .Reset(rst), .bus_io(busB));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Rules-level model: lives count down per accepted hit, a window lasts
  // RTK ticks of modular time, the invulnerable variant ignores hits inside it.
  task automatic modelStep(input int k, input logic [NP-1:0] h, input bit r, input int t);
    int alive;
    int el;
    bit expd;
    bit acc;
    bit retrig;
    retrig = (k == 0);
    if (r) begin
      for (int p = 0; p < NP; p++) begin
        mLives[k][p] = LV; mStart[k][p] = 0; mIn[k][p] = 0;
        mDead[k][p] = 0;  mAck[k][p] = 0;   mRed[k][p] = 0;
      end
      mGo[k] = 0;
      return;
    end
    alive = 0;
    for (int p = 0; p < NP; p++) if (!mDead[k][p]) alive++;
    for (int p = 0; p < NP; p++) begin
      mAck[k][p] = 0;
      if (!mDead[k][p]) begin
        el   = ((t - mStart[k][p]) % TMOD + TMOD) % TMOD;
        expd = mIn[k][p] && (el >= RTK);
        acc  = h[p] && (!mIn[k][p] || retrig || expd);
        if (acc) begin
          mLives[k][p]--;
          mAck[k][p] = 1;
          if (mLives[k][p] == 0) begin
            mDead[k][p] = 1;
            mIn[k][p]   = 0;
          end else begin
            mIn[k][p]    = 1;
            mStart[k][p] = t;
          end
        end else if (expd) begin
          mIn[k][p] = 0;
        end
      end
`ifdef HIT_TRACKER_BLINK_EN
      mRed[k][p] = mIn[k][p] && t[1];
`else
      mRed[k][p] = mIn[k][p];
`endif
    end
    mGo[k] = (alive <= 1);
  endtask

  task automatic checkAll();
    logic [NP-1:0]    oRed, oAck, oDead;
    logic [NP*LW-1:0] oLives;
    logic             oGo;
    string            nm;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        oRed = busA.red; oAck = busA.hit_ack; oDead = busA.dead;
        oLives = busA.lives; oGo = busA.game_over; nm = "A";
      end else begin
        oRed = busB.red; oAck = busB.hit_ack; oDead = busB.dead;
        oLives = busB.lives; oGo = busB.game_over; nm = "B";
      end
      for (int p = 0; p < NP; p++) begin
        checkOutput($sformatf("%s.red%0d", nm, p),   int'(oRed[p]),  int'(mRed[k][p]));
        checkOutput($sformatf("%s.ack%0d", nm, p),   int'(oAck[p]),  int'(mAck[k][p]));
        checkOutput($sformatf("%s.dead%0d", nm, p),  int'(oDead[p]), int'(mDead[k][p]));
        checkOutput($sformatf("%s.lives%0d", nm, p), int'(oLives[p*LW +: LW]), mLives[k][p]);
      end
      checkOutput($sformatf("%s.game_over", nm), int'(oGo), int'(mGo[k]));
    end
  endtask

  // One clock: drive on the falling edge, update model and compare after the rising edge
  task automatic applyStimulus(input logic [NP-1:0] h, input bit r, input int t);
    @(negedge clk);
    rst        = r;
    busA.hit   = h;
    busB.hit   = h;
    busA.timer = TW'(t);
    busB.timer = TW'(t);
    @(posedge clk);
    #1;
    modelStep(0, h, r, t % TMOD);
    modelStep(1, h, r, t % TMOD);
    checkAll();
  endtask

  task automatic runIdle(input int fromT, input int toT);
    for (int t = fromT; t <= toT; t++) applyStimulus('0, 1'b0, t % TMOD);
  endtask

  initial begin
    int curT;
    logic [NP-1:0] h;
    bit r;
    busA.hit = '0; busB.hit = '0; busA.timer = '0; busB.timer = '0;

    // Reset, single hit on player 0, window runs out after timer 0x028
    applyStimulus('0, 1'b1, 'h01E);
    applyStimulus('0, 1'b1, 'h01F);
    applyStimulus(2'b01, 1'b0, 'h020);
    checkOutput("dirA.lives0", int'(busA.lives[0 +: LW]), 2);
    checkOutput("dirA.red0", int'(busA.red[0]), 1);
    checkOutput("dirA.lives1", int'(busA.lives[LW +: LW]), 3);
    runIdle('h021, 'h02A);
    checkOutput("dirA.red0.end", int'(busA.red[0]), 0);

    // Window straddling timer wrap
    applyStimulus('0, 1'b1, 'h3FA);
    applyStimulus(2'b01, 1'b0, 'h3FC);
    runIdle('h3FD, 'h3FF);
    runIdle('h000, 'h003);
    checkOutput("wrap.red0.hold", int'(busA.red[0]), 1);
    applyStimulus('0, 1'b0, 'h004);
    checkOutput("wrap.red0.clear", int'(busA.red[0]), 0);

    // Invulnerable variant ignores 0x044, accepts at the expiry tick 0x048
    applyStimulus('0, 1'b1, 'h03F);
    applyStimulus(2'b01, 1'b0, 'h040);
    runIdle('h041, 'h043);
    applyStimulus(2'b01, 1'b0, 'h044);
    checkOutput("invB.ack0.ignored", int'(busB.hit_ack[0]), 0);
    checkOutput("invB.lives0.kept", int'(busB.lives[0 +: LW]), 2);
    runIdle('h045, 'h047);
    applyStimulus(2'b01, 1'b0, 'h048);
    checkOutput("invB.lives0.expiry", int'(busB.lives[0 +: LW]), 1);
    checkOutput("invB.red0.restart", int'(busB.red[0]), 1);
    runIdle('h049, 'h052);

    // Player 1 loses all lives, game over one cycle later, further hits dead
    applyStimulus('0, 1'b1, 'h0FF);
    for (int t = 'h100; t <= 'h12A; t++)
      applyStimulus((t == 'h100 || t == 'h110 || t == 'h120 || t == 'h122 || t == 'h124) ? 2'b10 : 2'b00,
                    1'b0, t);
    checkOutput("death.dead1", int'(busA.dead[1]), 1);
    checkOutput("death.game_over", int'(busA.game_over), 1);
    checkOutput("death.lives1", int'(busA.lives[LW +: LW]), 0);

    // Simultaneous hits on both players
    applyStimulus('0, 1'b1, 'h1FF);
    applyStimulus(2'b11, 1'b0, 'h200);
    checkOutput("both.ack", int'(busA.hit_ack), 3);
    runIdle('h201, 'h20A);

    // Reset mid-window discards a coincident hit
    applyStimulus('0, 1'b1, 'h2FF);
    applyStimulus(2'b01, 1'b0, 'h300);
    runIdle('h301, 'h30F);
    applyStimulus(2'b01, 1'b0, 'h310);
    applyStimulus('0, 1'b0, 'h311);
    applyStimulus(2'b01, 1'b1, 'h312);
    checkOutput("rst.lives0", int'(busA.lives[0 +: LW]), 3);
    checkOutput("rst.red0", int'(busA.red[0]), 0);
    runIdle('h313, 'h316);

    // Randomised traffic with skipping/holding timer and occasional reset
    curT = 'h316;
    for (int n = 0; n < 3000; n++) begin
      curT = (curT + int'($urandom_range(0, 3))) % TMOD;
      for (int p = 0; p < NP; p++) h[p] = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 149) == 0);
      applyStimulus(h, r, curT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
